fixed_shrink_stream: RTL and testbench
======================================

// Module: fixed_shrink_stream
// PURPOSE
// Streaming fixed-point hard/soft-shrink activation with a registered 2-stage pipeline and full valid/ready backpressure.
// Runtime-selectable mode and threshold, latched per tensor; P0*P1 lanes per beat; tensor-beat counter with last flag.
// Casts input precision to output precision with saturation. Sits between mase linear/norm stages in the activation library.
// PARAMETERS
// DATA_IN_0_PRECISION_0        8   input word width (signed two's complement)
// DATA_IN_0_PRECISION_1        4   input fractional bits
// DATA_IN_0_TENSOR_SIZE_DIM_0  10  tensor size, dim 0
// DATA_IN_0_TENSOR_SIZE_DIM_1  1   tensor size, dim 1
// DATA_IN_0_PARALLELISM_DIM_0  2   lanes per beat, dim 0; must divide TENSOR_SIZE_DIM_0
// DATA_IN_0_PARALLELISM_DIM_1  1   lanes per beat, dim 1; must divide TENSOR_SIZE_DIM_1
// DATA_OUT_0_PRECISION_0       8   output word width (signed)
// DATA_OUT_0_PRECISION_1       4   output fractional bits
// DATA_OUT_0_* tensor/parallelism parameters must equal the DATA_IN_0_* ones.
// PORTS
// clk               in   1                  clock
// rst               in   1                  synchronous, active-high reset
// cfg_mode          in   1                  0 = hardshrink, 1 = softshrink
// cfg_lambda        in   IN_W-1             threshold, unsigned, input fixed-point format
// data_in_0         in   IN_W x NLANE       input lanes; NLANE = P0*P1
// data_in_0_valid   in   1                  input beat valid
// data_in_0_ready   out  1                  input beat accepted when valid&&ready
// data_out_0        out  OUT_W x NLANE      output lanes (registered)
// data_out_0_valid  out  1                  output beat valid
// data_out_0_last   out  1                  high on the final beat of each tensor
// data_out_0_ready  in   1                  downstream ready
// BEHAVIOUR
// - One clock domain. Reset is synchronous, active-high.
// - Reset clears: s1/s2 valids, data_out_0_valid, data_out_0_last, data_out_0 (all 0), beat counter (0), latched cfg (mode=hard, lambda=0).
// - Reset mid-tensor discards in-flight beats; the next accepted beat starts a new tensor.
// - BEATS = (T0*T1)/(P0*P1). The input beat counter increments on each accepted beat and wraps BEATS-1 -> 0.
// - The last flag travels with the beat through the pipeline.
// - cfg_mode/cfg_lambda are latched only on the accepted beat with counter==0. That beat and the rest of its tensor use the latched values.
// - cfg changes mid-tensor have no effect until the next tensor.
// - Stage 1 computes per lane on IN_W+1-bit signed values:
//   - hard: |x|>L -> x, else 0.
//   - soft: x>L -> x-L; x<-L -> x+L; else 0.
//   - Comparisons are strict, so x==±L -> 0.
//   - x=-2^(IN_W-1) is handled without overflow.
// - Stage 2 casts to OUT precision:
//   - If OUT_FRAC<IN_FRAC: arithmetic right shift (truncation toward -inf).
//   - If OUT_FRAC>IN_FRAC: left shift.
//   - Then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
// - Handshake:
//   - s2 advances when !s2_valid || data_out_0_ready.
//   - s1 advances when !s1_valid || s2 advances.
//   - data_in_0_ready = s1 advance; a combinational path from data_out_0_ready is permitted.
// - Latency is 2 cycles from input accept to data_out_0_valid. Throughput is 1 beat/cycle when unstalled.
// - While data_out_0_valid && !data_out_0_ready, data_out_0, data_out_0_last and data_out_0_valid hold stable.
// - No beat is dropped or duplicated.
// - Boundaries:
//   - L=0: hard passes every nonzero x.
//   - L >= max|x|: all outputs 0, except x=-2^(IN_W-1) when L < 2^(IN_W-1).
//   - BEATS=1: every beat latches cfg and carries last=1.
// STRUCTURE
// - fixed_shrink_pkg: typedef enum logic {SHRINK_HARD, SHRINK_SOFT} shrink_mode_t;
// - fixed_shrink_pkg: function beats(T0,T1,P0,P1); function sat_cast for the width/fraction conversion.
// - Sub-module fixed_shrink_lane: combinational shrink + cast for one lane, instanced NLANE times.
// - Pipeline registers, beat counter and cfg latch live in the top module.
// TESTING (IN 8b/4f, OUT 8b/4f, L=8 i.e. 0.5, NLANE=2, BEATS=5 unless stated)
// 1. Hard mode, lanes {0x10,0x08},{0xF8,0xF0} -> {0x10,0x00},{0x00,0xF0}; valid exactly 2 cycles after accept.
// 2. Soft mode, lanes {0x10,0xF0},{0x80,0x08} -> {0x08,0xF8},{0x88,0x00}.
// 3. OUT 4b/1f, hard L=8: 0x50->0x7 (sat), 0xE0->0xC, 0x19->0x3, 0x90->0x8 (sat).
// 4. Random ready toggling over 20 tensors vs. reference model.
//    -> order and values exact, outputs stable during stall, last on every 5th output beat.
// 5. Flip cfg_mode/cfg_lambda on beat 2 of a tensor -> unchanged results until beat 0 of next tensor, new cfg from then.
// 6. Assert rst with 2 beats in flight at beat 3 -> valid/last drop next cycle.
//    -> Next accepted beat latches cfg and last appears after 5 beats.

Source files
------------

// File: rtl/fixed_shrink_pkg.sv
// Shared types and elaboration-time helpers for the fixed-point shrink stream.
package fixed_shrink_pkg;

   typedef enum logic {SHRINK_HARD = 1'b0, SHRINK_SOFT = 1'b1} shrink_mode_t;

   function automatic int beats(int t0, int t1, int p0, int p1);
      return (t0 * t1) / (p0 * p1);
   endfunction

   // Re-align the binary point (arithmetic shift), then clamp to the signed output range.
   function automatic int sat_cast(int x, int in_frac, int out_frac, int out_w);
      int y;
      int hi;
      int lo;
      if (out_frac < in_frac) y = x >>> (in_frac - out_frac);
      else                    y = x <<< (out_frac - in_frac);
      hi = (1 <<< (out_w - 1)) - 1;
      lo = -(1 <<< (out_w - 1));
      if (y > hi)      y = hi;
      else if (y < lo) y = lo;
      return y;
   endfunction

endpackage

// File: rtl/fixed_shrink_stream_if.sv
// Valid/ready beat stream into and out of the shrink block.
interface fixed_shrink_stream_if #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 8,
   parameter int NLANE = 2
);
   logic [NLANE*IN_W-1:0]  data_in_0;
   logic                   data_in_0_valid;
   logic                   data_in_0_ready;
   logic [NLANE*OUT_W-1:0] data_out_0;
   logic                   data_out_0_valid;
   logic                   data_out_0_last;
   logic                   data_out_0_ready;

   modport slave (
      input  data_in_0, data_in_0_valid, data_out_0_ready,
      output data_in_0_ready, data_out_0, data_out_0_valid, data_out_0_last
   );

   modport master (
      output data_in_0, data_in_0_valid, data_out_0_ready,
      input  data_in_0_ready, data_out_0, data_out_0_valid, data_out_0_last
   );
endinterface

// File: rtl/fixed_shrink_lane.sv
// One lane: shrink on the widened input, and the precision cast of a registered shrink result.
module fixed_shrink_lane
   import fixed_shrink_pkg::*;
#(
   parameter int IN_W     = 8,
   parameter int IN_FRAC  = 4,
   parameter int OUT_W    = 8,
   parameter int OUT_FRAC = 4
) (
   input  logic signed [IN_W-1:0]  x_i,
   input  shrink_mode_t            mode_i,
   input  logic        [IN_W-2:0]  lambda_i,
   output logic signed [IN_W:0]    shr_o,
   input  logic signed [IN_W:0]    shr_i,
   output logic signed [OUT_W-1:0] y_o
);

   logic signed [IN_W:0] x_ext;
   logic signed [IN_W:0] l_pos;
   logic signed [IN_W:0] l_neg;

   // One extra bit keeps -2^(IN_W-1) and -L representable.
   always_comb begin
      x_ext = {x_i[IN_W-1], x_i};
      l_pos = {2'b00, lambda_i};
      l_neg = -l_pos;
      shr_o = '0;
      if (x_ext > l_pos)      shr_o = (mode_i == SHRINK_SOFT) ? x_ext - l_pos : x_ext;
      else if (x_ext < l_neg) shr_o = (mode_i == SHRINK_SOFT) ? x_ext + l_pos : x_ext;
   end

   assign y_o = OUT_W'(sat_cast(int'(shr_i), IN_FRAC, OUT_FRAC, OUT_W));

endmodule

// File: rtl/fixed_shrink_stream.sv
// Two-stage hard/soft-shrink stream: stage 1 shrinks, stage 2 casts; per-tensor cfg latch and beat counter.
module fixed_shrink_stream
   import fixed_shrink_pkg::*;
#(
   parameter int DATA_IN_0_PRECISION_0       = 8,
   parameter int DATA_IN_0_PRECISION_1       = 4,
   parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
   parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
   parameter int DATA_IN_0_PARALLELISM_DIM_0 = 2,
   parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
   parameter int DATA_OUT_0_PRECISION_0      = 8,
   parameter int DATA_OUT_0_PRECISION_1      = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              cfg_mode,
   input  logic [DATA_IN_0_PRECISION_0-2:0]  cfg_lambda,
   fixed_shrink_stream_if.slave              bus
);

   localparam int IN_W  = DATA_IN_0_PRECISION_0;
   localparam int OUT_W = DATA_OUT_0_PRECISION_0;
   localparam int NLANE = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
   localparam int BEATS = beats(DATA_IN_0_TENSOR_SIZE_DIM_0, DATA_IN_0_TENSOR_SIZE_DIM_1,
                                DATA_IN_0_PARALLELISM_DIM_0, DATA_IN_0_PARALLELISM_DIM_1);
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   shrink_mode_t           mode_q, mode_eff;
   logic [IN_W-2:0]        lambda_q, lambda_eff;
   logic                   s1_valid_q, s1_last_q;
   logic signed [IN_W:0]   s1_data_q [NLANE];
   logic signed [IN_W:0]   shr_d [NLANE];
   logic                   s2_valid_q, s2_last_q;
   logic [NLANE*OUT_W-1:0] s2_data_q, cast_d;
   logic                   s1_adv, s2_adv, in_fire, cnt_first, cnt_last;

   assign s2_adv    = !s2_valid_q || bus.data_out_0_ready;
   assign s1_adv    = !s1_valid_q || s2_adv;
   assign in_fire   = bus.data_in_0_valid && s1_adv;
   assign cnt_first = (cnt_q == '0);
   assign cnt_last  = (cnt_q == CNT_LAST);
   assign cnt_d     = cnt_last ? '0 : cnt_q + CNT_W'(1);

   // The first beat of a tensor uses live cfg so it sees the same values it latches.
   assign mode_eff   = cnt_first ? shrink_mode_t'(cfg_mode) : mode_q;
   assign lambda_eff = cnt_first ? cfg_lambda : lambda_q;

   for (genvar g = 0; g < NLANE; g++) begin : g_lane
      fixed_shrink_lane #(
         .IN_W     (IN_W),
         .IN_FRAC  (DATA_IN_0_PRECISION_1),
         .OUT_W    (OUT_W),
         .OUT_FRAC (DATA_OUT_0_PRECISION_1)
      ) u_lane (
         .x_i      (bus.data_in_0[g*IN_W +: IN_W]),
         .mode_i   (mode_eff),
         .lambda_i (lambda_eff),
         .shr_o    (shr_d[g]),
         .shr_i    (s1_data_q[g]),
         .y_o      (cast_d[g*OUT_W +: OUT_W])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         mode_q     <= SHRINK_HARD;
         lambda_q   <= '0;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_data_q  <= '0;
         for (int i = 0; i < NLANE; i++) s1_data_q[i] <= '0;
      end else begin
         if (in_fire) begin
            cnt_q     <= cnt_d;
            s1_last_q <= cnt_last;
            for (int i = 0; i < NLANE; i++) s1_data_q[i] <= shr_d[i];
            if (cnt_first) begin
               mode_q   <= mode_eff;
               lambda_q <= lambda_eff;
            end
         end
         if (s1_adv) s1_valid_q <= bus.data_in_0_valid;
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_valid_q && s1_last_q;
            if (s1_valid_q) s2_data_q <= cast_d;
         end
      end
   end

   assign bus.data_in_0_ready  = s1_adv;
   assign bus.data_out_0       = s2_data_q;
   assign bus.data_out_0_valid = s2_valid_q;
   assign bus.data_out_0_last  = s2_last_q;

endmodule

// File: tb/tb_fixed_shrink_stream.sv
// Directed and randomised-backpressure checks of fixed_shrink_stream (8b/4f -> 8b/4f, plus a 4b/1f instance).
module tb_fixed_shrink_stream;

   localparam int BEATS = 5;

   typedef struct packed {
      logic [15:0] d;
      logic        l;
   } exp_t;

   // {mode, lambda, data_in {lane1,lane0}, expected {lane1,lane0}}
   localparam logic [47:0] T5 [20] = '{
      48'h00_08_E030_E030, 48'h00_08_E030_E030, 48'h01_20_E030_E030, 48'h01_20_E030_E030,
      48'h01_20_E030_E030, 48'h01_20_E030_0010, 48'h00_08_E030_0010, 48'h00_08_E030_0010,
      48'h00_08_E030_0010, 48'h00_08_E030_0010, 48'h00_00_0001_0001, 48'h01_7F_FF80_FF80,
      48'h01_7F_7F81_7F81, 48'h01_7F_7F81_7F81, 48'h00_7F_0001_0001, 48'h00_7F_7F80_0080,
      48'h00_7F_817F_0000, 48'h00_7F_8080_8080, 48'h00_7F_0101_0000, 48'h01_00_7F80_0080
   };

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_mode;
   logic [6:0] cfg_lambda;
   logic       cfg3_mode;
   logic [6:0] cfg3_lambda;

   int    n_cmp = 0;
   int    n_err = 0;
   int    tb_cnt;
   logic  tb_mode;
   logic [6:0] tb_lam;
   exp_t  q [$];
   logic  hold_pend;
   logic [15:0] hold_d;
   logic  hold_l;

   fixed_shrink_stream_if #(.IN_W(8), .OUT_W(8), .NLANE(2)) bus ();
   fixed_shrink_stream_if #(.IN_W(8), .OUT_W(4), .NLANE(2)) bus3 ();

   fixed_shrink_stream u_dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_mode   (cfg_mode),
      .cfg_lambda (cfg_lambda),
      .bus        (bus.slave)
   );

   fixed_shrink_stream #(
      .DATA_OUT_0_PRECISION_0 (4),
      .DATA_OUT_0_PRECISION_1 (1)
   ) u_dut3 (
      .clk        (clk),
      .rst        (rst),
      .cfg_mode   (cfg3_mode),
      .cfg_lambda (cfg3_lambda),
      .bus        (bus3.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_lane(input logic [7:0] x, input logic m, input logic [6:0] l);
      int xi;
      int li;
      int r;
      xi = int'($signed(x));
      li = int'(l);
      r  = 0;
      if (!m) begin
         if (xi > li || xi < -li) r = xi;
      end else begin
         if (xi > li)       r = xi - li;
         else if (xi < -li) r = xi + li;
      end
      return r[7:0];
   endfunction

   // Called on a negedge; drives one cycle, checks outputs, records accepts, returns on the next negedge.
   task automatic cycle(input logic vld, input logic [15:0] din, input logic rdy,
                        input logic hand, input logic [15:0] hexp, output logic fired);
      exp_t e;
      bus.data_in_0        = din;
      bus.data_in_0_valid  = vld;
      bus.data_out_0_ready = rdy;
      #1;
      if (hold_pend) begin
         chk("hold_valid", bus.data_out_0_valid, 1);
         chk("hold_data", bus.data_out_0, hold_d);
         chk("hold_last", bus.data_out_0_last, hold_l);
      end
      if (bus.data_out_0_valid && bus.data_out_0_ready) begin
         if (q.size() == 0) chk("unexpected_out", bus.data_out_0_valid, 0);
         else begin
            e = q.pop_front();
            chk("out_data", bus.data_out_0, e.d);
            chk("out_last", bus.data_out_0_last, e.l);
         end
      end
      hold_pend = bus.data_out_0_valid && !bus.data_out_0_ready;
      hold_d    = bus.data_out_0;
      hold_l    = bus.data_out_0_last;
      fired     = vld && bus.data_in_0_ready;
      if (fired) begin
         if (tb_cnt == 0) begin
            tb_mode = cfg_mode;
            tb_lam  = cfg_lambda;
         end
         e.d = hand ? hexp : {ref_lane(din[15:8], tb_mode, tb_lam), ref_lane(din[7:0], tb_mode, tb_lam)};
         e.l = (tb_cnt == BEATS - 1);
         tb_cnt = (tb_cnt == BEATS - 1) ? 0 : tb_cnt + 1;
         q.push_back(e);
      end
      @(negedge clk);
   endtask

   initial begin
      logic f;
      logic [47:0] row;
      logic [15:0] din;
      logic v;
      logic r;
      int sent;

      rst = 1'b1;
      cfg_mode = 1'b0;  cfg_lambda = 7'd8;
      cfg3_mode = 1'b0; cfg3_lambda = 7'd8;
      bus.data_in_0 = '0;  bus.data_in_0_valid = 1'b0;  bus.data_out_0_ready = 1'b1;
      bus3.data_in_0 = '0; bus3.data_in_0_valid = 1'b0; bus3.data_out_0_ready = 1'b1;
      tb_cnt = 0; tb_mode = 1'b0; tb_lam = '0; hold_pend = 1'b0; hold_d = '0; hold_l = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", bus.data_out_0_valid, 0);
      chk("rst_last", bus.data_out_0_last, 0);
      chk("rst_data", bus.data_out_0, 0);
      chk("rst3_valid", bus3.data_out_0_valid, 0);
      chk("rst3_data", bus3.data_out_0, 0);
      rst = 1'b0;

      // hard, L=0.5, with latency check
      cycle(1, 16'h0810, 1, 1, 16'h0010, f);
      chk("t1_lat1", bus.data_out_0_valid, 0);
      cycle(1, 16'hF0F8, 1, 1, 16'hF000, f);
      chk("t1_lat2", bus.data_out_0_valid, 1);
      chk("t1_b0", bus.data_out_0, 16'h0010);
      for (int i = 0; i < 3; i++) cycle(1, 16'h3333, 1, 0, 16'h0, f);
      for (int i = 0; i < 4; i++) cycle(0, 16'h0, 1, 0, 16'h0, f);
      chk("t1_drain", q.size(), 0);

      // soft, L=0.5
      cfg_mode = 1'b1;
      cycle(1, 16'hF010, 1, 1, 16'hF808, f);
      cycle(1, 16'h0880, 1, 1, 16'h0088, f);
      for (int i = 0; i < 3; i++) cycle(1, 16'hC040, 1, 0, 16'h0, f);
      for (int i = 0; i < 4; i++) cycle(0, 16'h0, 1, 0, 16'h0, f);
      chk("t2_drain", q.size(), 0);

      // 4b/1f output instance, hard L=0.5
      bus3.data_in_0_valid = 1'b1;
      bus3.data_in_0 = 16'hE050;
      @(negedge clk);
      bus3.data_in_0 = 16'h9019;
      @(negedge clk);
      bus3.data_in_0_valid = 1'b0;
      #1;
      chk("t3_valid_a", bus3.data_out_0_valid, 1);
      chk("t3_a", bus3.data_out_0, 8'hC7);
      @(negedge clk);
      #1;
      chk("t3_b", bus3.data_out_0, 8'h83);
      @(negedge clk);

      // cfg flips mid-tensor, plus lambda boundaries
      for (int i = 0; i < 20; i++) begin
         row = T5[i];
         cfg_mode   = row[40];
         cfg_lambda = row[38:32];
         cycle(1, row[31:16], 1, 1, row[15:0], f);
      end
      for (int i = 0; i < 4; i++) cycle(0, 16'h0, 1, 0, 16'h0, f);
      chk("t5_drain", q.size(), 0);

      // random backpressure and cfg over 20 tensors
      sent = 0;
      din  = 16'($urandom);
      for (int c = 0; c < 3000 && (sent < 100 || q.size() != 0); c++) begin
         cfg_mode   = 1'($urandom);
         cfg_lambda = 7'($urandom_range(0, 127));
         v = (sent < 100) && ($urandom_range(0, 3) != 0);
         r = (sent >= 100) || ($urandom_range(0, 1) == 1);
         cycle(v, din, r, 0, 16'h0, f);
         if (f) begin
            sent++;
            din = 16'($urandom);
         end
      end
      chk("t4_sent", sent, 100);
      chk("t4_drain", q.size(), 0);

      // reset with two beats in flight at beat 3
      cfg_mode = 1'b0; cfg_lambda = 7'd8;
      for (int i = 0; i < 4; i++) cycle(1, 16'hE030, 1, 1, 16'hE030, f);
      chk("t6_inflight", bus.data_out_0_valid, 1);
      rst = 1'b1;
      bus.data_in_0_valid = 1'b0;
      @(negedge clk);
      chk("t6_rst_valid", bus.data_out_0_valid, 0);
      chk("t6_rst_last", bus.data_out_0_last, 0);
      chk("t6_rst_data", bus.data_out_0, 0);
      rst = 1'b0;
      q.delete();
      hold_pend = 1'b0;
      tb_cnt = 0;
      cfg_mode = 1'b1; cfg_lambda = 7'h20;
      cycle(1, 16'hE030, 1, 1, 16'h0010, f);
      cfg_mode = 1'b0; cfg_lambda = 7'd8;
      for (int i = 0; i < 4; i++) cycle(1, 16'hE030, 1, 1, 16'h0010, f);
      for (int i = 0; i < 4; i++) cycle(0, 16'h0, 1, 0, 16'h0, f);
      chk("t6_drain", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
